// File: rtl/uart_phy_8n1.sv
// uart_phy_8n1: 8N1 UART PHY with independent TX and RX.
// Optional internal loopback is built only when UART_PHY_LOOPBACK_EN is defined.
module uart_phy_8n1 #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             uart_txd,
`ifdef UART_PHY_LOOPBACK_EN
  input  logic             loopback,
`endif
  input  logic             uart_rxd,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             rx_frame_err,
  output logic             rx_overrun
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [DIV_W-1:0] eff_div;
  assign eff_div = (divisor < DIV_W'(4)) ? DIV_W'(4) : divisor;

  // ---------------- transmitter ----------------
  tx_state_t        tx_state;
  logic [DIV_W-1:0] tx_div;
  logic [DIV_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_line;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt == tx_div - DIV_W'(1));

  // TX frame sequencer; tx_ready is registered and only high in TX_IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_ready <= 1'b0;
      tx_line  <= 1'b1;
      tx_div   <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_state <= TX_START;
            tx_ready <= 1'b0;
            tx_line  <= 1'b0;
            tx_div   <= eff_div;
            tx_shift <= tx_data;
            tx_cnt   <= '0;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_in;
`ifdef UART_PHY_LOOPBACK_EN
  assign rx_in    = loopback ? tx_line : uart_rxd;
  assign uart_txd = loopback ? 1'b1 : tx_line;
`else
  assign rx_in    = uart_rxd;
  assign uart_txd = tx_line;
`endif

  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rxs;
  logic                   rx_prev;

  assign rxs = rx_sync[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous serial input, idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_sync <= '1;
    else          rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_in};
  end

  // Previous synchronized level for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_prev <= 1'b1;
    else          rx_prev <= rxs;
  end

  rx_state_t        rx_state;
  logic [DIV_W-1:0] rx_div;
  logic [DIV_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_brk;
  logic             rx_bit_end;
  logic             rx_half;

  assign rx_bit_end = (rx_cnt == rx_div - DIV_W'(1));
  assign rx_half    = (rx_cnt == (rx_div >> 1) - DIV_W'(1));

  // RX frame sequencer plus output holding register and status pulses.
  // The cycle in which the edge is seen counts toward the half-bit delay,
  // hence rx_cnt starts at 1; after a bad stop bit rx_brk holds RX_STOP
  // until the line returns high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= RX_IDLE;
      rx_div       <= '0;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_brk       <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rxs) begin
            rx_state <= RX_START;
            rx_div   <= eff_div;
            rx_cnt   <= DIV_W'(1);
          end
        end
        RX_START: begin
          if (rx_half) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            if (rxs) rx_state <= RX_IDLE;
            else     rx_state <= RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rxs, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_brk) begin
            if (rxs) begin
              rx_brk   <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (rx_bit_end) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_state <= RX_IDLE;
              if (rx_valid && !rx_ready) begin
                rx_overrun <= 1'b1;
              end else begin
                rx_valid <= 1'b1;
                rx_data  <= rx_shift;
              end
            end else begin
              rx_frame_err <= 1'b1;
              rx_brk       <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy_8n1.sv
// Self-checking bench for uart_phy_8n1 (covers UART_PHY_LOOPBACK_EN when defined).
module tb_uart_phy_8n1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] divisor;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        uart_txd;
  logic        uart_rxd;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_frame_err;
  logic        rx_overrun;
`ifdef UART_PHY_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_phy_8n1 #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .divisor(divisor),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .uart_txd(uart_txd),
`ifdef UART_PHY_LOOPBACK_EN
    .loopback(loopback),
`endif
    .uart_rxd(uart_rxd), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // TX: a frame is 10 bits {stop, data, start}, bit i holds for d cycles,
  // busy for 10*d cycles after acceptance, divisor clamped to >= 4.
  logic        m_busy, m_rdy, m_txd;
  logic [9:0]  m_frame;
  int unsigned m_n, m_div;
  // RX: bytes expected to be presented, in order.
  logic [7:0]  rxq[$];
  int          exp_err = 0, exp_ovr = 0, obs_err = 0, obs_ovr = 0, n_rcvd = 0;

  function automatic int unsigned eff(input int unsigned d);
    return (d < 4) ? 4 : d;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_rdy = 1'b0; m_txd = 1'b1; m_n = 0; m_div = 4;
      rxq.delete();
    end else begin
      if (m_busy) begin
        m_n++;
        if (m_n == 10 * m_div) m_busy = 1'b0;
      end else if (m_rdy && tx_valid) begin
        m_busy = 1'b1; m_n = 0; m_div = eff(divisor);
        m_frame = {1'b1, tx_data, 1'b0};
      end
      m_rdy = !m_busy;
      m_txd = m_busy ? m_frame[m_n / m_div] : 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic exp_txd;
    if (reset_n) begin
`ifdef UART_PHY_LOOPBACK_EN
      exp_txd = loopback ? 1'b1 : m_txd;
`else
      exp_txd = m_txd;
`endif
      chk("uart_txd", uart_txd, exp_txd);
      chk("tx_ready", tx_ready, m_rdy);
      if (rx_valid) begin
        chk("rx_expected", rxq.size() != 0, 1);
        if (rxq.size() != 0) begin
          chk("rx_data", rx_data, rxq[0]);
          if (rx_ready) begin
            void'(rxq.pop_front());
            n_rcvd++;
          end
        end
      end
      if (rx_frame_err) obs_err++;
      if (rx_overrun)   obs_ovr++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_tx(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    chk("tx_accept", ok, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int unsigned d, input logic stop,
                         input int unsigned alt);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int unsigned i = 0; i < 10; i++) begin
      if (i == 9) begin
        if (!stop) exp_err++;
        else if (rxq.size() != 0 && !rx_ready) exp_ovr++;
        else rxq.push_back(b);
      end
      uart_rxd = f[i];
      if (i == 1) divisor = 16'(alt);
      repeat (d) @(posedge clk);
      #1;
    end
    uart_rxd = 1'b1;
    divisor  = 16'(d);
    repeat (2 * d) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap;
    int         low;
    reset_n = 1'b0; divisor = 16'd4; tx_valid = 1'b0; tx_data = 8'h00;
    uart_rxd = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_txd", uart_txd, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_frame_err", rx_frame_err, 0);
    chk("rst_overrun", rx_overrun, 0);
    reset_n = 1'b1;
    #1 chk("tx_ready_before_edge", tx_ready, 0);
    @(posedge clk); #1;
    chk("tx_ready_first_edge", tx_ready, 1);

    // 0xA5 at divisor 4: mid-bit waveform and busy length
    send_tx(8'hA5);
    low = 0;
    cap = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k % 4 == 2 && k / 4 < 10) cap[k / 4] = uart_txd;
      if (!tx_ready) low++;
    end
    chk("a5_bits", cap, 10'b1101001010);
    chk("a5_busy_cycles", low, 40);

    // Clamped divisor, back-to-back bytes, mid-frame divisor change
    divisor = 16'd2;
    send_tx(8'h5A);
    divisor = 16'd6;
    send_tx(8'h3C);
    repeat (15) @(posedge clk);
    #1 divisor = 16'd9;
    send_tx(8'hC1);
    repeat (100) @(posedge clk);
    #1 divisor = 16'd8;

    // RX: clean frame with divisor changed mid-frame, glitch, good frame, bad stop
    send_rx(8'h3C, 8, 1'b1, 5);
    uart_rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_no_err", obs_err, 0);
    send_rx(8'h55, 8, 1'b1, 8);
    send_rx(8'h81, 8, 1'b0, 8);
    chk("bad_stop_err", obs_err, 1);

    // TX and RX concurrently
    fork
      send_tx(8'hE7);
      send_rx(8'h96, 8, 1'b1, 8);
    join
    repeat (40) @(posedge clk);
    #1;

    // Overrun: consumer stalled over two frames
    rx_ready = 1'b0;
    send_rx(8'h11, 8, 1'b1, 8);
    send_rx(8'h22, 8, 1'b1, 8);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_pulses", obs_ovr, 1);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("ovr_drained", rx_valid, 0);

    // Reset in the middle of a TX frame
    divisor = 16'd4;
    send_tx(8'h0F);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_txd", uart_txd, 1);
    chk("midrst_ready", tx_ready, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

`ifdef UART_PHY_LOOPBACK_EN
    loopback = 1'b1;
    divisor  = 16'd5;
    rxq.push_back(8'hC3);
    send_tx(8'hC3);
    low = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!uart_txd) low++;
    end
    chk("lb_txd_low_cycles", low, 0);
    chk("lb_received", n_rcvd, 5);
    send_tx(8'h3A);
    repeat (19) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("lb_rst_txd", uart_txd, 1);
    @(negedge clk) reset_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("lb_rst_no_delivery", rx_valid, 0);
    chk("lb_final_received", n_rcvd, 5);
`else
    chk("final_received", n_rcvd, 4);
`endif
    chk("final_err_total", obs_err, exp_err);
    chk("final_ovr_total", obs_ovr, exp_ovr);
    chk("final_queue_empty", rxq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
